// File: rtl/updown_sweep_ctrl.sv
// Sweep sequencer around a saturating up/down count register.
// Runs single up-ramps, single down-ramps or continuous triangle sweeps
// between latched lo/hi limits, with an optional dwell at each endpoint.
// All outputs come straight from registers.
module updown_sweep_ctrl #(
  parameter int unsigned SIZE    = 4,
  parameter int unsigned DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [SIZE-1:0]    lo,
  input  logic [SIZE-1:0]    hi,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SIZE-1:0]    count,
  output logic               dir,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  localparam logic [1:0] ModeUp   = 2'b00;
  localparam logic [1:0] ModeDown = 2'b01;
  localparam logic [1:0] ModeRsvd = 2'b11;

  typedef enum logic [2:0] {StIdle, StUp, StDwellHi, StDown, StDwellLo} state_e;

  state_e             state_q, state_d;
  logic [SIZE-1:0]    count_q, count_d;
  logic               dir_q, dir_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cfg_err_q, cfg_err_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [1:0]         mode_q, mode_d;
  logic [SIZE-1:0]    lo_q, lo_d;
  logic [SIZE-1:0]    hi_q, hi_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;

  // With lo == hi there is nowhere to move, so turnarounds must not step.
  logic flat;
  assign flat = (lo_q == hi_q);

  // Next-state, count and status decode; stop overrides everything once running.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    dir_d       = dir_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;
    dwell_cnt_d = dwell_cnt_q;
    mode_d      = mode_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    dwell_d     = dwell_q;

    if (state_q != StIdle && stop) begin
      state_d = StIdle;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start && !stop) begin
            if (lo > hi || mode == ModeRsvd) begin
              cfg_err_d = 1'b1;
            end else begin
              mode_d  = mode;
              lo_d    = lo;
              hi_d    = hi;
              dwell_d = dwell;
              busy_d  = 1'b1;
              if (mode == ModeDown) begin
                count_d = hi;
                dir_d   = 1'b0;
                state_d = StDown;
              end else begin
                count_d = lo;
                dir_d   = 1'b1;
                state_d = StUp;
              end
            end
          end
        end

        StUp: begin
          if (count_q != hi_q) begin
            count_d = count_q + SIZE'(1);
          end else if (mode_q == ModeUp) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (dwell_q == '0) begin
            // Turnaround edge already takes the first step down.
            state_d = StDown;
            dir_d   = 1'b0;
            if (!flat) count_d = count_q - SIZE'(1);
          end else begin
            state_d     = StDwellHi;
            dwell_cnt_d = dwell_q - DWELL_W'(1);
          end
        end

        StDwellHi: begin
          if (dwell_cnt_q == '0) begin
            state_d = StDown;
            dir_d   = 1'b0;
            if (!flat) count_d = count_q - SIZE'(1);
          end else begin
            dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
          end
        end

        StDown: begin
          if (count_q != lo_q) begin
            count_d = count_q - SIZE'(1);
          end else if (mode_q == ModeDown) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (dwell_q == '0) begin
            state_d = StUp;
            dir_d   = 1'b1;
            if (!flat) count_d = count_q + SIZE'(1);
          end else begin
            state_d     = StDwellLo;
            dwell_cnt_d = dwell_q - DWELL_W'(1);
          end
        end

        StDwellLo: begin
          if (dwell_cnt_q == '0) begin
            state_d = StUp;
            dir_d   = 1'b1;
            if (!flat) count_d = count_q + SIZE'(1);
          end else begin
            dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
          end
        end

        default: begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      count_q     <= '0;
      dir_q       <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      dwell_cnt_q <= '0;
      mode_q      <= ModeUp;
      lo_q        <= '0;
      hi_q        <= '0;
      dwell_q     <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      dir_q       <= dir_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
      dwell_cnt_q <= dwell_cnt_d;
      mode_q      <= mode_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      dwell_q     <= dwell_d;
    end
  end

  assign count   = count_q;
  assign dir     = dir_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: doc/updown_sweep_ctrl.md
Name: updown_sweep_ctrl

Overview:
Sequencer that owns a saturating up/down count register and steps it through programmed sweeps between a low and a high limit. It supports single up-ramps, single down-ramps and continuous triangle sweeps with an optional dwell at each endpoint. It sits beside the up/down counter datapath and drives downstream logic such as DAC codes, PWM duty and test patterns. It exposes a start/stop handshake with busy and done status.

Parameters:
SIZE, 4, width of count, lo and hi
DWELL_W, 4, width of the dwell field in cycles

Ports:
clk  input  1  clock; all state changes on its rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  request a sweep; sampled only in IDLE
stop  input  1  synchronous abort; effective in any state
mode  input  2  00 up-ramp, 01 down-ramp, 10 triangle continuous, 11 reserved
lo  input  SIZE  lower limit
hi  input  SIZE  upper limit
dwell  input  DWELL_W  cycles spent at each endpoint in triangle mode; 0 means no dwell
count  output  SIZE  current count value
dir  output  1  1 = counting up or dwelling at hi; 0 = counting down or dwelling at lo
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when a single ramp completes
cfg_err  output  1  one-cycle pulse when a start is rejected

Behaviour:
- Reset (async, any state): state=IDLE, count=0, dir=1, busy=0, done=0, cfg_err=0, dwell counter=0.
- All outputs are registered. done and cfg_err are single-cycle pulses and deassert on the following edge.
- States: IDLE, UP, DWELL_HI, DOWN, DWELL_LO.
- IDLE, stop=1: start is ignored; stop wins.
- IDLE, start=1 with lo>hi or mode=11:
  - cfg_err=1 for one cycle.
  - State stays IDLE; count is unchanged.
- IDLE, start=1 with a valid config:
  - mode, lo, hi and dwell are latched into internal registers.
  - mode 00 or 10: count<=lo, dir<=1, state<=UP.
  - mode 01: count<=hi, dir<=0, state<=DOWN.
  - busy<=1.
- Config inputs are ignored while busy; only the latched copies are used.
- start while busy is ignored.
- UP, count!=hi_r: count<=count+1.
- UP, count==hi_r (count never exceeds hi_r):
  - mode 00: state<=IDLE, busy<=0, done<=1; count holds hi.
  - mode 10 with dwell_r=0: state<=DOWN, dir<=0.
  - mode 10 with dwell_r>0: state<=DWELL_HI, dwell counter<=dwell_r-1.
- DWELL_HI: count holds.
  - Dwell counter=0: state<=DOWN, dir<=0.
  - Otherwise the dwell counter decrements.
  - DWELL_HI therefore lasts exactly dwell_r cycles.
- DOWN mirrors UP: count decrements while count!=lo_r.
  - At count==lo_r, mode 01 completes: IDLE, done pulse, count holds lo.
  - At count==lo_r, mode 10 goes to DWELL_LO, or to UP when dwell_r=0.
  - On every entry to UP, dir<=1.
- DWELL_LO mirrors DWELL_HI.
- Triangle mode runs until stop; it never asserts done.
- stop=1 in any non-IDLE state:
  - Next state is IDLE, busy<=0, no done pulse.
  - count and dir hold their current values.
  - stop has priority over every other transition in the same cycle.
- lo==hi, mode 00: UP is entered with count==hi, so done follows one cycle after start acceptance.
- lo==hi, mode 10: the count is constant; dwell cycles still elapse and dir still toggles.
- Latency for an up-ramp accepted at edge E0: count=lo after E0 and increments at each edge; done is high after edge E0+(hi-lo)+1.
- Full-scale limits (lo=0, hi=2^SIZE-1): count never wraps.
- Dwell counter width is DWELL_W; a dwell of 2^DWELL_W-1 is legal.

Test Plan:
- Reset mid-sweep (triangle, count=7): assert rst asynchronously -> count=0, dir=1, busy=0, done=0 immediately, without waiting for a clock edge; the next start begins a fresh sweep.
- Up-ramp, SIZE=4, lo=2, hi=5, mode=00, start pulse at E0 -> count 2,3,4,5 after E0..E3; done=1 and busy=0 after E4; count holds 5; done=0 after E5.
- Down-ramp, lo=0, hi=15, mode=01 -> count 15 down to 0 over 16 cycles with no wrap to 15; done pulse one cycle after count reaches 0; dir=0 throughout.
- Triangle, lo=3, hi=6, dwell=2 -> count sequence 3,4,5,6,6,6,5,4,3,3,3,4,...; dir=1 through the hi dwell and 0 through the lo dwell; no done. Repeat with dwell=0 -> 3,4,5,6,5,4,3,4,...
- Config errors:
  - start with lo=9, hi=4 -> cfg_err=1 for one cycle; busy stays 0 and count is unchanged.
  - start with mode=11 -> same response.
  - start together with stop in IDLE -> nothing happens.
- Stop and config isolation:
  - Triangle running, stop asserted at count=5 going down -> IDLE next cycle, count=5, dir=0, no done.
  - Changing hi while busy has no effect on the running sweep.
  - start while busy is ignored.
